port_sdm_multi: RTL

Multi-channel first-order sigma-delta modulator behind an 8-bit processor I/O port. It is the parametrised successor of the single-channel `port_sdcm` port. The processor writes a level per channel through the `addr`/`w_strobe`/`din` port bus, using byte writes with double-buffered commit. Each channel drives one 1-bit pulse-density output at a rate set by a programmable tick divider.

---
 rtl/port_sdm_multi.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/port_sdm_multi.sv
// Multi-channel first-order sigma-delta DAC behind an 8-bit port; optional LFSR dither via SDM_DITHER_EN.
// Latency: register writes land on the strobe edge, readback one cycle after addr, levels apply on the next tick.
// Backpressure: none, every write is accepted immediately and the modulators free-run on the tick divider.
module port_sdm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                w_strobe,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic [CHANNELS-1:0] sd_out
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(2 * CHANNELS);
  localparam logic [ADDR_W-1:0] DIV_ADDR  = ADDR_W'(2 * CHANNELS + 1);

  logic                wr_vld;
  logic [7:0]          shadow   [CHANNELS];
  logic [WIDTH-1:0]    pending  [CHANNELS];
  logic [WIDTH-1:0]    active   [CHANNELS];
  logic [WIDTH-1:0]    acc      [CHANNELS];
  logic [WIDTH-1:0]    level    [CHANNELS];
  logic [WIDTH:0]      sum      [CHANNELS];
  logic [CHANNELS-1:0] pend_flag;
  logic [CHANNELS-1:0] lo_wr;
  logic [CHANNELS-1:0] hi_wr;
  logic [CHANNELS-1:0] mask;
  logic                dith_en;
  logic                dither_bit;
  logic [7:0]          div;
  logic [7:0]          cnt;
  logic                tick;
  logic [7:0]          rd_dat;

  assign wr_vld = enable & w_strobe;
  assign tick   = (cnt == div);

`ifdef SDM_DITHER_EN
  logic [15:0] lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dith_en <= 1'b0;
    end else if (wr_vld && addr == CTRL_ADDR) begin
      dith_en <= din[7];
    end
  end

  assign dither_bit = dith_en & lfsr[0];
`else
  assign dith_en    = 1'b0;
  assign dither_bit = 1'b0;
`endif

  always_comb begin
    lo_wr = '0;
    hi_wr = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lo_wr[k] = wr_vld && (addr == ADDR_W'(2 * k));
      hi_wr[k] = wr_vld && (addr == ADDR_W'(2 * k + 1));
    end
  end

  // A pending level is consumed by the same tick that loads it into active.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      level[k] = pend_flag[k] ? pending[k] : active[k];
      sum[k]   = {1'b0, acc[k]} + {1'b0, level[k]} + (WIDTH+1)'(dither_bit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k]  <= '0;
        pending[k] <= '0;
        active[k]  <= '0;
        acc[k]     <= '0;
      end
      pend_flag <= '0;
      sd_out    <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (lo_wr[k]) begin
          shadow[k] <= din;
        end
        if (tick && pend_flag[k]) begin
          active[k] <= pending[k];
        end
        // A HI write landing on a tick re-arms the flag so it is seen on the following tick.
        if (hi_wr[k]) begin
          pending[k]   <= WIDTH'({din, shadow[k]});
          pend_flag[k] <= 1'b1;
        end else if (tick) begin
          pend_flag[k] <= 1'b0;
        end
        if (tick) begin
          if (mask[k]) begin
            acc[k]    <= sum[k][WIDTH-1:0];
            sd_out[k] <= sum[k][WIDTH];
          end else begin
            acc[k]    <= '0;
            sd_out[k] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      div  <= '0;
      cnt  <= '0;
    end else begin
      if (wr_vld && addr == CTRL_ADDR) begin
        mask <= din[CHANNELS-1:0];
      end
      if (wr_vld && addr == DIV_ADDR) begin
        div <= din;
        cnt <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (addr == ADDR_W'(2 * k)) begin
        rd_dat = pending[k][7:0];
      end else if (addr == ADDR_W'(2 * k + 1)) begin
        rd_dat = 8'(16'(pending[k]) >> 8);
      end
    end
    if (addr == CTRL_ADDR) begin
      rd_dat = 8'(mask) | {dith_en, 7'b0};
    end else if (addr == DIV_ADDR) begin
      rd_dat = div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else begin
      dout <= enable ? rd_dat : 8'h00;
    end
  end

endmodule
